// File: rtl/occ_burst_packer_pkg.sv
// Shared types and constants for the occupancy-code burst packer.
// The burst word record is the FIFO entry layout: {data, keep, last}.
package occ_burst_packer_pkg;

    localparam int BURST_SIZE = 64;
    localparam int OCC_WIDTH  = 8;
    localparam int LANES      = BURST_SIZE / OCC_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [BURST_SIZE-1:0] data;
        logic [LANES-1:0]      keep;
        logic                  last;
    } burst_word_t;

endpackage

// File: rtl/occ_fifo.sv
// Synchronous FIFO for packed burst words; head is read combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module occ_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is left unreset so it can map onto distributed/block RAM.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/occ_burst_packer.sv
// Packs 8-bit occupancy codes into burst words, queues them, and on BFS
// completion flushes a keep-masked final word tagged last.
module occ_burst_packer
    import occ_burst_packer_pkg::*;
#(
    parameter int BURST_SIZE = occ_burst_packer_pkg::BURST_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_occ_valid,
    input  logic [7:0]              i_occ_code,
    output logic                    o_occ_ready,
    input  logic                    i_finish_bfs,
    output logic                    o_burst_valid,
    output logic [BURST_SIZE-1:0]   o_burst_data,
    output logic [BURST_SIZE/8-1:0] o_burst_keep,
    output logic                    o_burst_last,
    input  logic                    i_burst_ready,
    output logic [15:0]             o_word_count,
    output logic                    o_done
);

    localparam int NL = BURST_SIZE / 8;
    localparam int IW = $clog2(NL);
    localparam int FW = BURST_SIZE + NL + 1;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BURST_SIZE-1:0] pack_q, pack_d;
    logic [15:0]         count_q, count_d;
    logic                done_q, done_d;

    logic                fifo_full, fifo_empty;
    logic                push, pop, accept;
    logic [FW-1:0]       push_word, head_word;
    logic [BURST_SIZE-1:0] pack_ins;
    logic [NL-1:0]       flush_keep;

    // pack_ins is the pack register with the incoming code dropped into lane idx.
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        assign pack_ins[gi*8 +: 8] = (idx_q == IW'(gi)) ? i_occ_code : pack_q[gi*8 +: 8];
        assign flush_keep[gi]      = ({1'b0, idx_q} > (IW+1)'(gi));
    end

    assign accept = (state_q == ST_COLLECT) && i_occ_valid && !fifo_full;
    assign pop    = !fifo_empty && i_burst_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pack_d    = pack_q;
        count_d   = count_q;
        done_d    = done_q;
        push      = 1'b0;
        push_word = {pack_ins, {NL{1'b1}}, 1'b0};
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                    pack_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (idx_q == IW'(NL-1)) begin
                        push    = 1'b1;
                        idx_d   = '0;
                        pack_d  = '0;
                        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    end else begin
                        pack_d = pack_ins;
                        idx_d  = idx_q + IW'(1);
                    end
                end
                if (i_finish_bfs) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Lanes at or above idx are already zero: pack is cleared after every full word.
                push_word = {pack_q, flush_keep, 1'b1};
                if (!fifo_full) begin
                    push    = 1'b1;
                    state_d = ST_DRAIN;
                    if (idx_q != '0) begin
                        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_word[0]) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pack_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pack_q  <= pack_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    occ_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (push_word),
        .i_pop   (pop),
        .o_head  (head_word),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Head fields are masked while empty so the bus reads zero out of reset.
    assign o_occ_ready   = (state_q == ST_COLLECT) && !fifo_full;
    assign o_burst_valid = !fifo_empty;
    assign o_burst_data  = fifo_empty ? '0 : head_word[FW-1 -: BURST_SIZE];
    assign o_burst_keep  = fifo_empty ? '0 : head_word[NL:1];
    assign o_burst_last  = !fifo_empty && head_word[0];
    assign o_word_count  = count_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_occ_burst_packer.sv
// Randomised bench for occ_burst_packer: a queue-based model predicts every
// output each cycle, and directed scenarios pin exact words and counts.
module tb_occ_burst_packer;

    localparam int BS    = 64;
    localparam int LN    = 8;
    localparam int DEPTH = 4;
    localparam int P_IDLE = 0, P_COLLECT = 1, P_FLUSH = 2, P_DRAIN = 3, P_DONE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          occ_valid = 1'b0;
    logic [7:0]    occ_code = 8'h00;
    logic          finish = 1'b0;
    logic          burst_ready = 1'b0;
    logic          o_occ_ready, o_burst_valid, o_burst_last, o_done;
    logic [BS-1:0] o_burst_data;
    logic [LN-1:0] o_burst_keep;
    logic [15:0]   o_word_count;

    always #5 clk = ~clk;

    occ_burst_packer #(.BURST_SIZE(BS), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_occ_valid   (occ_valid),
        .i_occ_code    (occ_code),
        .o_occ_ready   (o_occ_ready),
        .i_finish_bfs  (finish),
        .o_burst_valid (o_burst_valid),
        .o_burst_data  (o_burst_data),
        .o_burst_keep  (o_burst_keep),
        .o_burst_last  (o_burst_last),
        .i_burst_ready (burst_ready),
        .o_word_count  (o_word_count),
        .o_done        (o_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } mw_t;

    mw_t         mq[$];
    logic [7:0]  mb[$];
    int          m_phase = P_IDLE;
    int unsigned m_count = 0;
    bit          m_done = 1'b0;
    bit          m_live = 1'b0;
    bit          m_full, m_pop, m_push;
    mw_t         m_pw;

    function automatic mw_t mk_word(input bit last);
        mw_t w;
        w.d = '0;
        w.k = '0;
        w.l = last;
        for (int i = 0; i < mb.size(); i++) begin
            w.d[i*8 +: 8] = mb[i];
            w.k[i]        = 1'b1;
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            mb.delete();
            m_phase = P_IDLE;
            m_count = 0;
            m_done  = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_full = (mq.size() >= DEPTH);
            m_pop  = (mq.size() > 0) && burst_ready;
            m_push = 1'b0;
            case (m_phase)
                P_IDLE, P_DONE: begin
                    if (start) begin
                        m_phase = P_COLLECT;
                        mb.delete();
                        m_count = 0;
                        m_done  = 1'b0;
                    end
                end
                P_COLLECT: begin
                    if (occ_valid && !m_full) begin
                        mb.push_back(occ_code);
                        if (mb.size() == LN) begin
                            m_pw   = mk_word(1'b0);
                            m_push = 1'b1;
                            mb.delete();
                            if (m_count < 65535) m_count++;
                        end
                    end
                    if (finish) m_phase = P_FLUSH;
                end
                P_FLUSH: begin
                    if (!m_full) begin
                        m_pw   = mk_word(1'b1);
                        m_push = 1'b1;
                        if (mb.size() > 0 && m_count < 65535) m_count++;
                        mb.delete();
                        m_phase = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    if (m_pop && mq[0].l) begin
                        m_phase = P_DONE;
                        m_done  = 1'b1;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(m_pw);
        end
    end

    // Popped words as the DUT presented them, for literal checks.
    logic [72:0] dlog[$];

    always @(negedge clk) begin
        if (m_live) begin
            chk("occ_ready", 64'(o_occ_ready), 64'(m_phase == P_COLLECT && mq.size() < DEPTH));
            chk("burst_valid", 64'(o_burst_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("burst_data", o_burst_data, mq[0].d);
                chk("burst_keep", 64'(o_burst_keep), 64'(mq[0].k));
                chk("burst_last", 64'(o_burst_last), 64'(mq[0].l));
            end else begin
                chk("idle_data", o_burst_data, 64'd0);
                chk("idle_keep", 64'(o_burst_keep), 64'd0);
                chk("idle_last", 64'(o_burst_last), 64'd0);
            end
            chk("word_count", 64'(o_word_count), 64'(m_count));
            chk("done", 64'(o_done), 64'(m_done));
            if (o_burst_valid && burst_ready) dlog.push_back({o_burst_data, o_burst_keep, o_burst_last});
        end
    end

    // ---------------- stimulus ----------------
    bit rand_mode = 1'b0;
    always @(posedge clk) begin
        #2;
        if (rand_mode) burst_ready = 1'($urandom % 2);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input bit fin);
        bit acc;
        bit got;
        got       = 1'b0;
        occ_valid = 1'b1;
        occ_code  = c;
        for (int n = 0; n < 300; n++) begin
            acc    = o_occ_ready;
            finish = fin && acc;
            tick();
            if (acc) begin
                got = 1'b1;
                break;
            end
        end
        occ_valid = 1'b0;
        finish    = 1'b0;
        chk("send_accept", 64'(got), 64'd1);
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 500; n++) begin
            if (o_done) break;
            tick();
        end
        chk("done_wait", 64'(o_done), 64'd1);
    endtask

    task automatic chk_log(input string nm, input int i, input logic [63:0] d,
                           input logic [7:0] k, input logic l);
        logic [72:0] e;
        e = (i < dlog.size()) ? dlog[i] : 73'h0;
        chk({nm, "_data"}, e[72:9], d);
        chk({nm, "_keep"}, 64'(e[8:1]), 64'(k));
        chk({nm, "_last"}, 64'(e[0]), 64'(l));
    endtask

    initial begin
        logic [63:0] w;
        int          nc;

        // reset state
        repeat (3) tick();
        chk("rst_valid", 64'(o_burst_valid), 64'd0);
        chk("rst_data", o_burst_data, 64'd0);
        chk("rst_keep", 64'(o_burst_keep), 64'd0);
        chk("rst_last", 64'(o_burst_last), 64'd0);
        chk("rst_ready", 64'(o_occ_ready), 64'd0);
        chk("rst_count", 64'(o_word_count), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // two full words then a marker
        burst_ready = 1'b1;
        dlog.delete();
        do_start();
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        do_finish();
        wait_done();
        chk("t1_nwords", 64'(dlog.size()), 64'd3);
        chk_log("t1_w0", 0, 64'h0807060504030201, 8'hFF, 1'b0);
        chk_log("t1_w1", 1, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b0);
        chk_log("t1_w2", 2, 64'h0, 8'h00, 1'b1);
        chk("t1_count", 64'(o_word_count), 64'd2);
        $display("t1 words=%0d count=%0d", dlog.size(), o_word_count);

        // partial word flush
        dlog.delete();
        do_start();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        do_finish();
        wait_done();
        chk("t2_nwords", 64'(dlog.size()), 64'd1);
        chk_log("t2_w0", 0, 64'h0000000000CCBBAA, 8'h07, 1'b1);
        chk("t2_count", 64'(o_word_count), 64'd1);
        $display("t2 words=%0d count=%0d", dlog.size(), o_word_count);

        // backpressure: FIFO fills after 32 codes
        burst_ready = 1'b0;
        dlog.delete();
        do_start();
        for (int i = 0; i < 32; i++) send(8'(8'h40 + i), 1'b0);
        chk("t3_ready_low", 64'(o_occ_ready), 64'd0);
        chk("t3_valid", 64'(o_burst_valid), 64'd1);
        burst_ready = 1'b1;
        for (int i = 32; i < 40; i++) send(8'(8'h40 + i), 1'b0);
        do_finish();
        wait_done();
        chk("t3_nwords", 64'(dlog.size()), 64'd6);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8'h40 + k*8 + j);
            chk_log("t3_w", k, w, 8'hFF, 1'b0);
        end
        chk_log("t3_marker", 5, 64'h0, 8'h00, 1'b1);
        chk("t3_count", 64'(o_word_count), 64'd5);
        $display("t3 words=%0d count=%0d", dlog.size(), o_word_count);

        // finish coincident with 8th code
        dlog.delete();
        do_start();
        for (int i = 0; i < 7; i++) send(8'(8'h60 + i), 1'b0);
        send(8'h67, 1'b1);
        wait_done();
        chk("t4_nwords", 64'(dlog.size()), 64'd2);
        chk_log("t4_w0", 0, 64'h6766656463626160, 8'hFF, 1'b0);
        chk_log("t4_w1", 1, 64'h0, 8'h00, 1'b1);
        chk("t4_count", 64'(o_word_count), 64'd1);
        $display("t4 words=%0d count=%0d", dlog.size(), o_word_count);

        // reset mid-COLLECT with idx=5 and two words queued
        burst_ready = 1'b0;
        do_start();
        for (int i = 0; i < 21; i++) send(8'(8'h80 + i), 1'b0);
        chk("t5_pre_valid", 64'(o_burst_valid), 64'd1);
        chk("t5_pre_count", 64'(o_word_count), 64'd2);
        rst_n = 1'b0;
        tick();
        chk("t5_valid", 64'(o_burst_valid), 64'd0);
        chk("t5_count", 64'(o_word_count), 64'd0);
        chk("t5_ready", 64'(o_occ_ready), 64'd0);
        rst_n = 1'b1;
        burst_ready = 1'b1;
        dlog.delete();
        do_start();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        do_finish();
        wait_done();
        chk("t5_nwords", 64'(dlog.size()), 64'd1);
        chk_log("t5_w0", 0, 64'h0000000000002211, 8'h03, 1'b1);
        $display("t5 words=%0d count=%0d", dlog.size(), o_word_count);

        // randomized traversals with random downstream stalls
        rand_mode = 1'b1;
        for (int t = 0; t < 8; t++) begin
            dlog.delete();
            do_start();
            nc = int'($urandom_range(0, 40));
            for (int i = 0; i < nc; i++) begin
                repeat ($urandom % 3) tick();
                send(8'($urandom), (i == nc - 1) && ($urandom % 2 == 1));
            end
            if (m_phase == P_COLLECT) do_finish();
            wait_done();
            chk("rnd_nwords", 64'(dlog.size()), 64'(nc / 8 + 1));
            $display("rnd %0d codes=%0d words=%0d count=%0d", t, nc, dlog.size(), o_word_count);
        end
        rand_mode = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/occ_burst_packer.md
# occ_burst_packer

Downstream stage of the octree BFS traversal core. Accepts the stream of 8-bit occupancy codes the BFS core emits, one per visited node, and packs eight codes into each 64-bit burst word. Buffers words in a small FIFO and presents them to the DDR writer on a valid/ready interface. When the BFS core signals completion, it flushes a partial final word with a byte-keep mask and tags the last word.

## Interface
Parameters:
- BURST_SIZE, 64, burst word width in bits; must equal 8 × lane count
- FIFO_DEPTH, 4, burst words buffered; power of two, ≥ 2

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  reset; synchronous, active-low
- i_start  in  1  begin a new traversal; honoured only in IDLE or DONE
- i_occ_valid  in  1  occupancy code present
- i_occ_code  in  8  occupancy code (bit n = child n occupied)
- o_occ_ready  out  1  code accepted when valid && ready
- i_finish_bfs  in  1  BFS core has delivered its final code; level or pulse
- o_burst_valid  out  1  burst word available
- o_burst_data  out  BURST_SIZE  packed codes; first code in [7:0]
- o_burst_keep  out  BURST_SIZE/8  byte lane valid mask
- o_burst_last  out  1  final word of traversal
- i_burst_ready  in  1  DDR writer accepts word when valid && ready
- o_word_count  out  16  words pushed with non-zero keep since start; saturates at 16'hFFFF
- o_done  out  1  traversal fully drained

## Operation
- States: IDLE(0), COLLECT(1), FLUSH(2), DRAIN(3), DONE(4).
- IDLE/DONE: i_start → COLLECT. On entry, clear lane index, pack register and o_word_count. Clear o_done on leaving DONE.
- COLLECT:
  - o_occ_ready = !fifo_full.
  - Each accepted code is written into lane `idx`, and idx increments.
  - Accept at idx=7 pushes {pack with new byte, keep=8'hFF, last=0} and sets idx=0.
  - i_finish_bfs sampled high → FLUSH. A code accepted in the same cycle is packed first.
- FLUSH:
  - o_occ_ready=0.
  - When !fifo_full, push one terminal word with last=1 and go to DRAIN.
  - If idx>0: data = pack with unused lanes zero, keep = (1<<idx)-1.
  - If idx=0: data = 0, keep = 8'h00; this marker word is not counted.
- DRAIN: o_occ_ready=0. When the last=1 word is popped → DONE.
- DONE: o_done=1.
- Pop occurs on o_burst_valid && i_burst_ready. o_burst_valid = !fifo_empty. Data, keep and last come from the FIFO head.
- Simultaneous push and pop are legal at any fill level except a push when full, which is prevented by ready.
- i_occ_valid outside COLLECT is ignored. i_start outside IDLE/DONE is ignored.

## Timing
- Reset values:
  - state=IDLE, idx=0, FIFO empty.
  - o_occ_ready=0, o_burst_valid=0, o_burst_data=0, o_burst_keep=0, o_burst_last=0.
  - o_word_count=0, o_done=0.
- Latency: the 8th code accepted at edge N gives o_burst_valid=1 after edge N, visible in cycle N+1.
- FLUSH lasts ≥1 cycle; its push happens on the first cycle with !fifo_full.
- o_word_count updates on the same edge as the push.
- Reset asserted mid-traversal discards the partial pack and all FIFO contents. Outputs reach reset values at the next edge.

## Structure
- Shared package holds:
  - BURST_SIZE and OCC_WIDTH=8
  - state encodings IDLE..DONE
  - burst word record (data, keep, last)
- One sub-module: occ_fifo.
  - Synchronous FIFO, width BURST_SIZE+BURST_SIZE/8+1, depth FIFO_DEPTH.
  - Head output is combinational from memory.
  - Ports: full, empty, push, pop.
  - Same clock/reset convention.

## Test plan
- Start, feed codes 8'h01..8'h10 back-to-back with i_burst_ready=1, then finish → words 64'h0807060504030201 and 64'h100F0E0D0C0B0A09 (keep FF), then last marker (keep 00, last=1); o_word_count=2, o_done=1.
- Feed 3 codes AA,BB,CC, then finish → single word 64'h0000000000CCBBAA, keep=8'h07, last=1; o_word_count=1.
- Hold i_burst_ready=0 and feed 40 codes → o_occ_ready drops after the 32nd code (FIFO full). Release ready → all 5 words arrive in order with no loss or duplication.
- i_finish_bfs high in the same cycle as the 8th code → full word pushed (keep FF), then marker word (keep 00, last=1).
- Assert i_rst_n=0 mid-COLLECT with idx=5 and 2 words queued → next cycle o_burst_valid=0, o_word_count=0, state IDLE. A new start then packs from lane 0.
